reg_to_obi: RTL and testbench



---
 rtl/cei_mochila_pkg.sv | 4 +
 rtl/obi_pkg.sv | 16 +
 rtl/reg_pkg.sv | 16 +
 rtl/reg_to_obi.sv | 68 ++++++
 tb/tb_reg_to_obi.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/cei_mochila_pkg.sv
// cei_mochila_pkg: system-level constants shared by the bus system
package cei_mochila_pkg;
  localparam logic [31:0] REG_TO_OBI_ERR_DATA = 32'hBADCAB1E;
endpackage

// File: rtl/obi_pkg.sv
// obi_pkg: OBI initiator request/response types
package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

// File: rtl/reg_pkg.sv
// reg_pkg: register-bus request/response types
package reg_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

// File: rtl/reg_to_obi.sv
// reg_to_obi: reg-bus responder to OBI initiator bridge, one access in flight
module reg_to_obi
  import reg_pkg::*;
  import obi_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 256,
  parameter logic [31:0] ErrData       = cei_mochila_pkg::REG_TO_OBI_ERR_DATA
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  reg_req_t  reg_req_i,
  output reg_rsp_t  reg_rsp_o,
  output obi_req_t  obi_req_o,
  input  obi_resp_t obi_resp_i
);
  localparam int unsigned CntW = TimeoutCycles > 0 ? $clog2(TimeoutCycles + 1) : 1;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;
  state_e            r_state, w_next;
  logic [31:0]       r_addr, r_wdata, r_rdata;
  logic [3:0]        r_be;
  logic              r_we, r_err;
  logic [CntW-1:0]   r_cnt;
  logic              w_timeout;
  assign w_timeout = (TimeoutCycles != 0) && (r_cnt == CntW'(TimeoutCycles - 1));
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  // gnt takes priority over an expiring timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = reg_req_i.valid ? REQ : IDLE;
      REQ:     w_next = obi_resp_i.gnt ? RESP : (w_timeout ? DONE : REQ);
      RESP:    w_next = obi_resp_i.rvalid ? DONE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && reg_req_i.valid) begin
        r_addr  <= reg_req_i.addr;
        r_wdata <= reg_req_i.wdata;
        r_be    <= reg_req_i.wstrb;
        r_we    <= reg_req_i.write;
        r_cnt   <= '0;
      end
      if (r_state == REQ && !obi_resp_i.gnt) begin
        if (w_timeout) begin
          r_rdata <= ErrData;
          r_err   <= 1'b1;
        end else if (r_cnt != '1) r_cnt <= r_cnt + CntW'(1);
      end
      if (r_state == RESP && obi_resp_i.rvalid) begin
        r_rdata <= r_we ? 32'h0 : obi_resp_i.rdata;
        r_err   <= 1'b0;
      end
    end
  assign obi_req_o = '{req: r_state == REQ, we: r_we, be: r_be, addr: r_addr, wdata: r_wdata};
  assign reg_rsp_o = '{rdata: r_rdata, error: r_err, ready: r_state == DONE};
endmodule

// File: tb/tb_reg_to_obi.sv
// tb_reg_to_obi: directed cycle-exact checks of the reg-bus to OBI bridge
module tb_reg_to_obi;
  import reg_pkg::*;
  import obi_pkg::*;
  logic      clk = 1'b0;
  logic      rst;
  reg_req_t  rq;
  reg_rsp_t  rsp;
  obi_req_t  oq;
  obi_resp_t ors;
  int        n_total = 0;
  int        n_bad = 0;

  reg_to_obi #(.TimeoutCycles(4), .ErrData(32'hBADCAB1E)) dut (
    .clk_i(clk), .rst_i(rst), .reg_req_i(rq), .reg_rsp_o(rsp), .obi_req_o(oq), .obi_resp_i(ors)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    rq  = '0;
    ors = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(oq.req), 0);
    chk("rst_obi", 32'(oq.addr | oq.wdata), 0);
    chk("rst_be_we", 32'({oq.be, oq.we}), 0);
    chk("rst_rsp", 32'({rsp.ready, rsp.error}), 0);
    chk("rst_rdata", rsp.rdata, 0);
    rst = 1'b0;
    // read, zero-wait slave: ready in cycle 3
    @(negedge clk);
    rq = '{addr: 32'h0000_1000, write: 1'b0, wdata: 32'h0, wstrb: 4'hF, valid: 1'b1};
    @(negedge clk);
    chk("rd_req", 32'(oq.req), 1);
    chk("rd_addr", oq.addr, 32'h0000_1000);
    chk("rd_we", 32'(oq.we), 0);
    ors.gnt = 1'b1;
    @(negedge clk);
    chk("rd_req_drop", 32'(oq.req), 0);
    chk("rd_early_rdy", 32'(rsp.ready), 0);
    ors = '{gnt: 1'b0, rvalid: 1'b1, rdata: 32'hDEADBEEF};
    @(negedge clk);
    chk("rd_rdy", 32'(rsp.ready), 1);
    chk("rd_rdata", rsp.rdata, 32'hDEADBEEF);
    chk("rd_err", 32'(rsp.error), 0);
    ors = '0;
    rq.valid = 1'b0;
    @(negedge clk);
    chk("rd_rdy_pulse", 32'(rsp.ready), 0);
    chk("rd_rdata_hold", rsp.rdata, 32'hDEADBEEF);
    // write with 3-cycle gnt stall (gnt in last timeout cycle), stray rvalid in REQ, 2-cycle rvalid stall
    rq = '{addr: 32'h0000_2000, write: 1'b1, wdata: 32'h1234_5678, wstrb: 4'b0011, valid: 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wr_req", 32'(oq.req), 1);
      chk("wr_we", 32'(oq.we), 1);
      chk("wr_be", 32'(oq.be), 32'h3);
      chk("wr_wdata", oq.wdata, 32'h1234_5678);
      chk("wr_no_rdy", 32'(rsp.ready), 0);
      ors.rvalid = (i == 0);
      ors.rdata  = 32'h5555_5555;
      ors.gnt    = (i == 3);
    end
    @(negedge clk);
    chk("wr_req_drop", 32'(oq.req), 0);
    ors = '0;
    @(negedge clk);
    chk("wr_wait_rvalid", 32'(rsp.ready), 0);
    @(negedge clk);
    chk("wr_wait_rvalid2", 32'(rsp.ready), 0);
    ors = '{gnt: 1'b0, rvalid: 1'b1, rdata: 32'hFFFF_FFFF};
    @(negedge clk);
    chk("wr_rdy", 32'(rsp.ready), 1);
    chk("wr_rdata", rsp.rdata, 32'h0);
    chk("wr_err", 32'(rsp.error), 0);
    ors = '0;
    rq.valid = 1'b0;
    // timeout: no gnt, req high exactly 4 cycles
    @(negedge clk);
    rq = '{addr: 32'h0000_3000, write: 1'b0, wdata: 32'h0, wstrb: 4'hF, valid: 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_req", 32'(oq.req), 1);
    end
    @(negedge clk);
    chk("to_req_drop", 32'(oq.req), 0);
    chk("to_rdy", 32'(rsp.ready), 1);
    chk("to_err", 32'(rsp.error), 1);
    chk("to_rdata", rsp.rdata, 32'hBADCAB1E);
    rq.valid = 1'b0;
    @(negedge clk);
    chk("to_idle", 32'({rsp.ready, oq.req}), 0);
    // reset pulse in RESP, then a late rvalid
    rq = '{addr: 32'h0000_5000, write: 1'b0, wdata: 32'h0, wstrb: 4'hF, valid: 1'b1};
    @(negedge clk);
    chk("rs_req", 32'(oq.req), 1);
    ors.gnt = 1'b1;
    @(negedge clk);
    ors.gnt = 1'b0;
    rq.valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rs_obi", 32'({oq.req, oq.we, oq.be}), 0);
    chk("rs_addr", oq.addr, 0);
    chk("rs_rsp", 32'({rsp.ready, rsp.error}), 0);
    chk("rs_rdata", rsp.rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    ors = '{gnt: 1'b0, rvalid: 1'b1, rdata: 32'h7777_7777};
    @(negedge clk);
    ors = '0;
    chk("rs_late_rvalid", 32'(rsp.ready), 0);
    @(negedge clk);
    chk("rs_late_rvalid2", 32'(rsp.ready), 0);
    chk("rs_rdata_clear", rsp.rdata, 0);
    // back-to-back with valid held across both accesses
    rq = '{addr: 32'h0000_6000, write: 1'b0, wdata: 32'h0, wstrb: 4'hF, valid: 1'b1};
    @(negedge clk);
    chk("bb1_req", 32'(oq.req), 1);
    chk("bb1_addr", oq.addr, 32'h0000_6000);
    ors.gnt = 1'b1;
    @(negedge clk);
    ors = '{gnt: 1'b0, rvalid: 1'b1, rdata: 32'h1111_1111};
    @(negedge clk);
    ors = '0;
    chk("bb1_rdy", 32'(rsp.ready), 1);
    chk("bb1_rdata", rsp.rdata, 32'h1111_1111);
    rq = '{addr: 32'h0000_7000, write: 1'b1, wdata: 32'hCAFE_F00D, wstrb: 4'b1100, valid: 1'b1};
    @(negedge clk);
    chk("bb_gap", 32'({rsp.ready, oq.req}), 0);
    @(negedge clk);
    chk("bb2_req", 32'(oq.req), 1);
    chk("bb2_addr", oq.addr, 32'h0000_7000);
    chk("bb2_we_be", 32'({oq.we, oq.be}), 32'h1C);
    chk("bb2_wdata", oq.wdata, 32'hCAFE_F00D);
    ors.gnt = 1'b1;
    @(negedge clk);
    ors = '{gnt: 1'b0, rvalid: 1'b1, rdata: 32'h2222_2222};
    @(negedge clk);
    ors = '0;
    rq.valid = 1'b0;
    chk("bb2_rdy", 32'(rsp.ready), 1);
    chk("bb2_rdata", rsp.rdata, 32'h0);
    chk("bb2_err", 32'(rsp.error), 0);
    @(negedge clk);
    chk("end_idle", 32'({rsp.ready, oq.req}), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
